led_bar_animator: RTL and testbench

//  Parametrised LED bar-graph animation engine: drives a WIDTH-bit LED bar through one of four

---
 rtl/led_bar_animator_if.sv | 22 ++
 rtl/led_bar_animator.sv | 167 ++++++++++++++++
 tb/tb_led_bar_animator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/led_bar_animator_if.sv
// LED bar animator control/status bundle: pattern controls in, LED drive and step events out.
interface led_bar_animator_if #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 4
);
  logic                en;
  logic [1:0]          mode;
  logic [PWM_BITS-1:0] duty;
  logic [WIDTH-1:0]    out;
  logic                step_pulse;
  logic                cycle_done;

  modport master (
    output en, mode, duty,
    input  out, step_pulse, cycle_done
  );

  modport slave (
    input  en, mode, duty,
    output out, step_pulse, cycle_done
  );
endinterface

// File: rtl/led_bar_animator.sv
// WIDTH-LED bar animation engine: four patterns stepped every TICK_DIV clocks, leading LED
// PWM-dimmed by duty. All outputs registered.
//
// state      | meaning
// DIR_UP     | bounce pattern filling towards WIDTH
// DIR_DOWN   | bounce pattern draining towards 0
// PH_ON      | blink pattern showing all LEDs lit
// PH_OFF     | blink pattern showing all LEDs dark
module led_bar_animator #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 461,
  parameter int PWM_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  led_bar_animator_if.slave      bus
);

  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LVW = $clog2(WIDTH + 1);
  localparam int POW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
  localparam logic [LVW-1:0] LV_MAX  = LVW'(WIDTH);
  localparam logic [LVW-1:0] LV_ONE  = LVW'(1);
  localparam logic [POW-1:0] PO_MAX  = POW'(WIDTH - 1);

  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_CHASE  = 2'd1,
    M_FILL   = 2'd2,
    M_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1}    phase_e;

  logic [PSW-1:0]      presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [LVW-1:0]      lvl_q, lvl_d;
  logic [POW-1:0]      pos_q, pos_d;
  dir_e                dir_q, dir_d;
  phase_e              phase_q, phase_d;
  mode_e               mode_q, mode_d;
  logic                mode_vld_q, mode_vld_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                step_q, step_d;
  logic                done_q, done_d;

  mode_e mode_in;
  mode_e mode_cur;
  logic  mode_chg;
  logic  tick;
  logic  pwm_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q    <= '0;
      pwm_q      <= '0;
      lvl_q      <= LV_ONE;
      pos_q      <= '0;
      dir_q      <= DIR_UP;
      phase_q    <= PH_ON;
      mode_q     <= M_BOUNCE;
      mode_vld_q <= 1'b0;
      out_q      <= '0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      lvl_q      <= lvl_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      mode_vld_q <= mode_vld_d;
      out_q      <= out_d;
      step_q     <= step_d;
      done_q     <= done_d;
    end
  end

  // mode_q only becomes meaningful one clock after reset; until then the live input is
  // the selected mode, so the first clock never counts as a mode change.
  always_comb begin
    mode_in  = mode_e'(bus.mode);
    mode_cur = mode_vld_q ? mode_q : mode_in;
    mode_chg = mode_vld_q && (mode_in != mode_q);
    tick     = bus.en && (presc_q == PS_LAST);

    presc_d    = presc_q;
    pwm_d      = pwm_q + 1'b1;
    lvl_d      = lvl_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    phase_d    = phase_q;
    mode_d     = mode_in;
    mode_vld_d = 1'b1;
    step_d     = 1'b0;
    done_d     = 1'b0;

    if (mode_chg) begin
      presc_d = '0;
      lvl_d   = LV_ONE;
      pos_d   = '0;
      dir_d   = DIR_UP;
      phase_d = PH_ON;
    end else if (bus.en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        step_d = 1'b1;
        case (mode_cur)
          M_BOUNCE: begin
            if (dir_q == DIR_UP) begin
              lvl_d = lvl_q + 1'b1;
              if (lvl_q == LV_MAX - 1'b1) dir_d = DIR_DOWN;
              if (lvl_q == '0) done_d = 1'b1;
            end else begin
              lvl_d = lvl_q - 1'b1;
              if (lvl_q == LV_ONE) dir_d = DIR_UP;
            end
          end
          M_CHASE: begin
            if (pos_q == PO_MAX) begin
              pos_d  = '0;
              done_d = 1'b1;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end
          M_FILL: begin
            lvl_d = (lvl_q >= LV_MAX) ? '0 : lvl_q + 1'b1;
            if (lvl_q == '0) done_d = 1'b1;
          end
          M_BLINK: begin
            phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
            if (phase_q == PH_OFF) done_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output image is built from the current state, so LEDs follow a step one clock later.
  always_comb begin
    pwm_on = (bus.duty == '1) || (pwm_q < bus.duty);
    out_d  = '0;
    if (bus.en) begin
      case (mode_cur)
        M_CHASE: out_d[pos_q] = pwm_on;
        M_BLINK: out_d = (phase_q == PH_ON) ? '1 : '0;
        default: begin
          for (int i = 0; i < WIDTH; i++) begin
            out_d[i] = (i < int'(lvl_q)) && ((i != int'(lvl_q) - 1) || pwm_on);
          end
        end
      endcase
    end
  end

  assign bus.out        = out_q;
  assign bus.step_pulse = step_q;
  assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_led_bar_animator.sv
// Directed scoreboard bench for led_bar_animator: pattern sequences, mode switch, enable gating,
// async reset and leading-LED PWM duty.
module tb_led_bar_animator;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  led_bar_animator_if #(.WIDTH(8), .PWM_BITS(4)) bm ();
  led_bar_animator_if #(.WIDTH(8), .PWM_BITS(4)) bp ();

  led_bar_animator #(.WIDTH(8), .TICK_DIV(4), .PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .bus(bm)
  );

  led_bar_animator #(.WIDTH(8), .TICK_DIV(80), .PWM_BITS(4)) dut_pwm (
    .clk(clk), .rst(rst), .bus(bp)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] o, input logic d);
    exp_t e;
    e.out  = o;
    e.done = d;
    sb_q.push_back(e);
  endtask

  // Wait for each step pulse, check its spacing and cycle_done, then check the LED image
  // that appears one clock later against the next scoreboard entry.
  task automatic run_steps(input int n, input string tag, input int first_gap);
    exp_t e;
    int   waited;
    bit   seen;
    logic d;
    for (int k = 0; k < n; k++) begin
      waited = 0;
      seen   = 1'b0;
      while (!seen && waited < 20) begin
        @(negedge clk);
        waited++;
        seen = (bm.step_pulse === 1'b1);
      end
      check({tag, " gap"}, waited, (k == 0) ? first_gap : 3);
      d = bm.cycle_done;
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        e.out  = 'x;
        e.done = 'x;
      end
      check({tag, " out"}, bm.out, e.out);
      check({tag, " cycle_done"}, d, e.done);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int waited;
    int hi;
    int bad;

    rst     = 1'b1;
    bm.en   = 1'b1;
    bm.mode = 2'd0;
    bm.duty = 4'hF;
    bp.en   = 1'b1;
    bp.mode = 2'd0;
    bp.duty = 4'h4;

    repeat (3) @(negedge clk);
    check("reset out", bm.out, 8'h00);
    check("reset step", bm.step_pulse, 1'b0);
    check("reset done", bm.cycle_done, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    check("first out", bm.out, 8'h01);

    // bounce fill/drain
    push(8'h03, 0); push(8'h07, 0); push(8'h0F, 0); push(8'h1F, 0);
    push(8'h3F, 0); push(8'h7F, 0); push(8'hFF, 0); push(8'h7F, 0);
    push(8'h3F, 0); push(8'h1F, 0); push(8'h0F, 0); push(8'h07, 0);
    push(8'h03, 0); push(8'h01, 0); push(8'h00, 0); push(8'h01, 1);
    run_steps(16, "bounce", 3);

    // single-dot chase
    bm.mode = 2'd1;
    repeat (2) @(negedge clk);
    check("chase restart", bm.out, 8'h01);
    push(8'h02, 0); push(8'h04, 0); push(8'h08, 0); push(8'h10, 0);
    push(8'h20, 0); push(8'h40, 0); push(8'h80, 0); push(8'h01, 1);
    push(8'h02, 0);
    run_steps(9, "chase", 3);

    // back to bounce, then switch to fill-wrap on the clock that would tick
    bm.mode = 2'd0;
    repeat (2) @(negedge clk);
    check("bounce restart", bm.out, 8'h01);
    push(8'h03, 0); push(8'h07, 0);
    run_steps(2, "bounce2", 3);
    repeat (2) @(negedge clk);
    bm.mode = 2'd2;
    @(negedge clk);
    check("switch no step", {bm.step_pulse, bm.cycle_done}, 2'b00);
    @(negedge clk);
    check("fill restart", bm.out, 8'h01);
    push(8'h03, 0); push(8'h07, 0); push(8'h0F, 0);
    run_steps(3, "fill", 3);

    // freeze for 10 clocks mid-pattern
    bm.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("en low blank", {bm.out, bm.step_pulse, bm.cycle_done}, 10'h000);
    end
    bm.en = 1'b1;
    @(negedge clk);
    check("resume value", bm.out, 8'h0F);
    push(8'h1F, 0); push(8'h3F, 0); push(8'h7F, 0); push(8'hFF, 0);
    push(8'h00, 0); push(8'h01, 1); push(8'h03, 0);
    run_steps(7, "fill resume", 2);

    // blink-all
    bm.mode = 2'd3;
    repeat (2) @(negedge clk);
    check("blink restart", bm.out, 8'hFF);
    push(8'h00, 0); push(8'hFF, 1); push(8'h00, 0); push(8'hFF, 1);
    run_steps(4, "blink", 3);

    // reset during drain
    bm.mode = 2'd0;
    repeat (2) @(negedge clk);
    check("bounce3 restart", bm.out, 8'h01);
    push(8'h03, 0); push(8'h07, 0); push(8'h0F, 0); push(8'h1F, 0);
    push(8'h3F, 0); push(8'h7F, 0); push(8'hFF, 0); push(8'h7F, 0);
    push(8'h3F, 0);
    run_steps(9, "drain", 3);
    rst = 1'b1;
    #1;
    check("async reset out", bm.out, 8'h00);
    @(negedge clk);
    check("reset hold", {bm.out, bm.step_pulse, bm.cycle_done}, 10'h000);
    rst = 1'b0;
    @(negedge clk);
    check("post reset out", bm.out, 8'h01);
    push(8'h03, 0); push(8'h07, 0);
    run_steps(2, "post reset", 3);

    // leading-LED PWM on the slow instance, held at lvl=3
    cnt    = 0;
    waited = 0;
    while (cnt < 2 && waited < 400) begin
      @(negedge clk);
      waited++;
      if (bp.step_pulse === 1'b1) cnt++;
    end
    check("pwm step wait", cnt, 2);

    hi  = 0;
    bad = 0;
    repeat (32) begin
      @(negedge clk);
      if (bp.out[2] === 1'b1) hi++;
      if (bp.out[1:0] !== 2'b11 || bp.out[7:3] !== 5'b0) bad++;
    end
    check("pwm duty4 highs", hi, 8);
    check("pwm duty4 solid", bad, 0);

    bp.duty = 4'h0;
    hi  = 0;
    bad = 0;
    repeat (16) begin
      @(negedge clk);
      if (bp.out[2] === 1'b1) hi++;
      if (bp.out[1:0] !== 2'b11 || bp.out[7:3] !== 5'b0) bad++;
    end
    check("pwm duty0 highs", hi, 0);
    check("pwm duty0 solid", bad, 0);

    bp.duty = 4'hF;
    hi = 0;
    repeat (16) begin
      @(negedge clk);
      if (bp.out === 8'h07) hi++;
    end
    check("pwm dutyF on", hi, 16);

    check("scoreboard drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
